// File: rtl/hxd32_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hxd32_pipe_pkg
// Purpose  : Shared encodings and types for the hxd32 pipeline hazard unit.
//            Writeback-source and forwarding-select encodings, the shadow
//            scoreboard entry, and the hazard address-match helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hxd32_pipe_pkg;

  // Writeback source of an instruction
  localparam logic [1:0] RD_SEL_ALU  = 2'b00;
  localparam logic [1:0] RD_SEL_DRAM = 2'b01;
  localparam logic [1:0] RD_SEL_PC4  = 2'b10;
  localparam logic [1:0] RD_SEL_IMM  = 2'b11;

  // EX-stage operand source
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // One in-flight instruction as seen by the hazard unit
  typedef struct packed {
    logic       valid;
    logic       rd_wr_en;
    logic       is_load;
    logic [4:0] rd_addr;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic       rs1_used;
    logic       rs2_used;
  } sb_entry_t;

  // An entry only produces a hazard when it really writes a register other
  // than x0; x0 reads always come from the register file.
  function automatic logic sb_hit(input logic       valid,
                                  input logic       rd_wr_en,
                                  input logic [4:0] rd_addr,
                                  input logic [4:0] rs_addr);
    return valid && rd_wr_en && (rd_addr != 5'd0) && (rd_addr == rs_addr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hdu_fwd.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hdu_fwd
// Purpose  : Per-operand forwarding select for the EX stage. MEM has priority
//            over WB; a load result is only forwarded once it reaches WB.
// Ports    : i_rs_addr  - source register address of the EX operand
//            i_rs_used  - operand is live (EX valid and operand read)
//            i_mem_q    - scoreboard entry currently in MEM
//            i_wb_q     - scoreboard entry currently in WB
//            o_sel      - FWD_* operand source select
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hdu_fwd
  import hxd32_pipe_pkg::*;
(
  input  logic [4:0] i_rs_addr,
  input  logic       i_rs_used,
  input  sb_entry_t  i_mem_q,
  input  sb_entry_t  i_wb_q,
  output logic [1:0] o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;
  logic w_unused;

  assign w_mem_hit = sb_hit(i_mem_q.valid, i_mem_q.rd_wr_en, i_mem_q.rd_addr, i_rs_addr);
  assign w_wb_hit  = sb_hit(i_wb_q.valid, i_wb_q.rd_wr_en, i_wb_q.rd_addr, i_rs_addr);

  always_comb begin
    o_sel = FWD_RF;
    if (i_rs_used) begin
      // Load data is not available at the MEM forwarding point yet.
      if (w_mem_hit && !i_mem_q.is_load) begin
        o_sel = FWD_MEM;
      end else if (w_wb_hit) begin
        o_sel = FWD_WB;
      end
    end
  end

  // Source-operand fields of the downstream entries play no role here.
  assign w_unused = ^{i_mem_q.rs1_addr, i_mem_q.rs2_addr, i_mem_q.rs1_used, i_mem_q.rs2_used,
                      i_wb_q.rs1_addr, i_wb_q.rs2_addr, i_wb_q.rs1_used, i_wb_q.rs2_used,
                      i_wb_q.is_load};

endmodule
`default_nettype wire

// File: rtl/pipe_hdu.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hdu
// Purpose  : Hazard detection and forwarding unit for the hxd32 5-stage
//            pipeline. Shadows EX/MEM/WB destinations, raises load-use stalls,
//            stretches redirect flushes over the IMEM read latency and drives
//            the EX operand forwarding selects.
// Ports    : clk_i, rst_n_i        - clock, async active-low reset
//            id_*_i                - decoded fields of the ID instruction
//            ex_redirect_i         - taken branch/jump resolved in EX
//            stall_o               - hold PC and IF/ID, bubble into ID/EX
//            flush_o               - kill IF/ID and ID/EX
//            ex_fwd_a_sel_o/b_sel_o- EX operand sources (FWD_*)
//            ex_valid_o            - EX holds a real instruction
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hdu
  import hxd32_pipe_pkg::*;
#(
  parameter int unsigned FLUSH_LEN = 2  // legal range 1..7
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_rd_addr_i,
  input  logic [4:0] id_rs2_rd_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic       id_rd_wr_en_i,
  input  logic [1:0] id_rd_wr_sel_i,
  input  logic [4:0] id_rd_wr_addr_i,
  input  logic       ex_redirect_i,
  output logic       stall_o,
  output logic       flush_o,
  output logic [1:0] ex_fwd_a_sel_o,
  output logic [1:0] ex_fwd_b_sel_o,
  output logic       ex_valid_o
);

  localparam logic [2:0] c_flush_len = 3'(FLUSH_LEN);

  sb_entry_t  r_ex_q;
  sb_entry_t  r_mem_q;
  sb_entry_t  r_wb_q;
  logic [2:0] r_flush_cnt;

  sb_entry_t  w_ex_d;
  logic       w_flush;
  logic       w_ex_load;
  logic       w_load_use;
  logic       w_mem_load_conflict;

  // --------------------------------------------------------------------------
  // Flush: active in the redirect cycle itself, then FLUSH_LEN more cycles.
  // Outputs are forced quiet while reset is held.
  // --------------------------------------------------------------------------
  assign w_flush = (r_flush_cnt != 3'd0) || ex_redirect_i;
  assign flush_o = rst_n_i && w_flush;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_flush_cnt <= 3'd0;
    end else if (ex_redirect_i) begin
      r_flush_cnt <= c_flush_len;
    end else if (r_flush_cnt != 3'd0) begin
      r_flush_cnt <= r_flush_cnt - 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Load-use stall: a load in EX whose destination the ID instruction reads.
  // The ID instruction is dead during a flush, so flush suppresses the stall.
  // --------------------------------------------------------------------------
  assign w_ex_load  = r_ex_q.valid && r_ex_q.rd_wr_en && r_ex_q.is_load &&
                      (r_ex_q.rd_addr != 5'd0);
  assign w_load_use = id_valid_i && w_ex_load &&
                      ((id_rs1_used_i && (id_rs1_rd_addr_i == r_ex_q.rd_addr)) ||
                       (id_rs2_used_i && (id_rs2_rd_addr_i == r_ex_q.rd_addr)));
  assign stall_o    = rst_n_i && w_load_use && !w_flush;

  // --------------------------------------------------------------------------
  // Scoreboard shift
  // --------------------------------------------------------------------------
  always_comb begin
    w_ex_d = '0;
    if (id_valid_i && !stall_o && !w_flush) begin
      w_ex_d.valid    = 1'b1;
      w_ex_d.rd_wr_en = id_rd_wr_en_i;
      w_ex_d.is_load  = (id_rd_wr_sel_i == RD_SEL_DRAM);
      w_ex_d.rd_addr  = id_rd_wr_addr_i;
      w_ex_d.rs1_addr = id_rs1_rd_addr_i;
      w_ex_d.rs2_addr = id_rs2_rd_addr_i;
      w_ex_d.rs1_used = id_rs1_used_i;
      w_ex_d.rs2_used = id_rs2_used_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ex_q  <= '0;
      r_mem_q <= '0;
      r_wb_q  <= '0;
    end else begin
      r_ex_q  <= w_ex_d;
      r_mem_q <= r_ex_q;
      r_wb_q  <= r_mem_q;
    end
  end

  assign ex_valid_o = r_ex_q.valid;

  // --------------------------------------------------------------------------
  // Forwarding selects (flops only, no input-to-output path)
  // --------------------------------------------------------------------------
  pipe_hdu_fwd u_fwd_a (
    .i_rs_addr (r_ex_q.rs1_addr),
    .i_rs_used (r_ex_q.valid && r_ex_q.rs1_used),
    .i_mem_q   (r_mem_q),
    .i_wb_q    (r_wb_q),
    .o_sel     (ex_fwd_a_sel_o)
  );

  pipe_hdu_fwd u_fwd_b (
    .i_rs_addr (r_ex_q.rs2_addr),
    .i_rs_used (r_ex_q.valid && r_ex_q.rs2_used),
    .i_mem_q   (r_mem_q),
    .i_wb_q    (r_wb_q),
    .o_sel     (ex_fwd_b_sel_o)
  );

  // A load in MEM feeding a live EX operand means the load-use stall failed.
  assign w_mem_load_conflict =
      r_ex_q.valid && r_mem_q.is_load &&
      ((r_ex_q.rs1_used && sb_hit(r_mem_q.valid, r_mem_q.rd_wr_en, r_mem_q.rd_addr, r_ex_q.rs1_addr)) ||
       (r_ex_q.rs2_used && sb_hit(r_mem_q.valid, r_mem_q.rd_wr_en, r_mem_q.rd_addr, r_ex_q.rs2_addr)));

  a_no_mem_load_use : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                       !w_mem_load_conflict);

endmodule
`default_nettype wire

// File: doc/pipe_hdu.md
Name: pipe_hdu

Overview:
Hazard detection and forwarding unit for the hxd32 5-stage pipeline (IF/ID/EX/MEM/WB). It consumes the decoded register-address and writeback fields from the ID stage, the same signals that feed the ID/EX stage register. It keeps its own shadow scoreboard of in-flight destinations in EX, MEM and WB. From that scoreboard it drives load-use stalls, redirect flushes and the EX-stage operand forwarding selects.

Parameters:
FLUSH_LEN, 2, cycles flush_o stays asserted after a redirect; covers one cycle of synchronous IMEM read latency; legal range 1..7.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
id_valid_i  in  1  ID stage holds a real instruction
id_rs1_rd_addr_i  in  5  rs1 address of the ID instruction
id_rs2_rd_addr_i  in  5  rs2 address of the ID instruction
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
id_rd_wr_en_i  in  1  ID instruction writes rd
id_rd_wr_sel_i  in  2  writeback source of the ID instruction (RD_SEL_* encoding)
id_rd_wr_addr_i  in  5  rd address of the ID instruction
ex_redirect_i  in  1  branch/jump taken in EX (pc_wr_en resolved)
stall_o  out  1  hold PC and IF/ID; insert bubble into ID/EX
flush_o  out  1  kill IF/ID and ID/EX contents
ex_fwd_a_sel_o  out  2  operand A source for the EX instruction (FWD_* encoding)
ex_fwd_b_sel_o  out  2  operand B source for the EX instruction
ex_valid_o  out  1  EX stage holds a real instruction

Behaviour:
- Scoreboard: three entries ex_q, mem_q and wb_q. Each entry holds {valid, rd_wr_en, is_load, rd_addr, rs1_addr, rs2_addr, rs1_used, rs2_used}.
- is_load = (rd_wr_sel == RD_SEL_DRAM).
- Every cycle: wb_q <= mem_q and mem_q <= ex_q.
- ex_q <= bubble (valid = 0) if stall_o, flush_o or ex_redirect_i is high, or if id_valid_i = 0. Otherwise ex_q <= the ID fields.
- Hazard address match: an entry only counts if valid && rd_wr_en && rd_addr != 0. x0 is never a hazard and is never forwarded.
- Load-use stall (combinational from inputs and ex_q):
  - Condition: id_valid_i && ex_q is a load && (id_rs1_used_i && rs1 == ex_q.rd, or id_rs2_used_i && rs2 == ex_q.rd).
  - Exactly one bubble is inserted. The next cycle the load sits in MEM and the condition clears.
- Forwarding (combinational from flops only; no input-to-output path). Evaluated per operand of ex_q:
  - FWD_MEM (01): mem_q matches and is not a load.
  - Else FWD_WB (10): wb_q matches. Loads are forwarded only from WB.
  - Else FWD_RF (00).
  - Priority is MEM over WB. Selects are 00 when ex_q is invalid or the operand is unused.
  - A load in MEM matching an EX operand cannot occur because of the load-use stall. This is an assertion, not a function.
- Flush counter (3 bits):
  - ex_redirect_i loads the counter with FLUSH_LEN. Otherwise the counter decrements while nonzero.
  - flush_o = (counter != 0) || ex_redirect_i, so the flush takes effect in the same cycle as the redirect.
  - A redirect while a flush is active reloads the counter to FLUSH_LEN.
- Simultaneous events:
  - Redirect or active flush together with a load-use condition: flush wins and stall_o = 0, because the ID instruction is being killed.
  - stall_o is never asserted while flush_o = 1.
- ex_valid_o = ex_q.valid.
- Reset (asynchronous, mid-operation included): all scoreboard valid bits 0, counter 0.
  - Outputs during and after reset: stall_o = 0, flush_o = 0, ex_fwd_a_sel_o = 00, ex_fwd_b_sel_o = 00, ex_valid_o = 0.
  - The first valid ID instruction after reset enters ex_q on the next edge.
- Latency: stall and flush act in the same cycle as their cause. Forwarding selects are valid in the cycle the consumer is in EX.

Decomposition:
- Package hxd32_pipe_pkg holds:
  - RD_SEL_ALU = 2'b00, RD_SEL_DRAM = 2'b01, RD_SEL_PC4 = 2'b10, RD_SEL_IMM = 2'b11.
  - FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10.
  - Packed struct sb_entry_t for the scoreboard entry.
- One sub-module, pipe_hdu_fwd: a combinational per-operand select that takes (rs_addr, rs_used, mem_q, wb_q). It is instantiated twice, once for A and once for B.

Test Plan:
- ADD x5 in ID, then SUB using rs1 = x5 on the next cycle -> SUB in EX gives ex_fwd_a_sel_o = 01; one cycle later a consumer of x5 gives 10.
- LW x7 followed immediately by ADD rs2 = x7 -> stall_o = 1 for exactly 1 cycle, one bubble in EX (ex_valid_o = 0), then ADD in EX with ex_fwd_b_sel_o = 10.
- Producer and consumer of x0 (rd = 0, rs1 = 0) back-to-back, including LW x0 -> no stall, fwd selects 00.
- ex_redirect_i pulse with FLUSH_LEN = 2 -> flush_o high for 3 cycles (redirect cycle plus 2), no valid ex_q entries enter; a second redirect in cycle 2 extends flush to cycle 4.
- Load-use condition coincident with ex_redirect_i -> stall_o = 0, flush_o = 1.
- Two in-flight writers of x3 (MEM and WB) with consumer rs1 = x3 -> select 01 (MEM priority); assert rst_n_i mid-sequence -> all outputs 0 immediately, ex_valid_o = 0.
